// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared types for the branch target buffer: the 2-bit direction counter
// encoding and the layout of one table entry.
// ---------------------------------------------------------------------------
package btb_pkg;

  // Width of the PC the buffer works on.
  localparam int PC_W = 16;

  // The entry tag field is sized for the widest possible tag so the struct
  // does not depend on the index width of a particular instance. Tags are
  // stored zero-extended (pc >> IDX_W), so unused upper bits stay 0.
  localparam int TAG_FIELD_W = PC_W;

  // 2-bit saturating direction counter; bit 1 set means "predict taken".
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // A freshly allocated entry starts weakly taken.
  localparam ctr_t CTR_ALLOC = CTR_WT;

  typedef struct packed {
    logic                   valid;
    logic [TAG_FIELD_W-1:0] tag;
    logic [PC_W-1:0]        target;
    ctr_t                   ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// ---------------------------------------------------------------------------
// sat_ctr2
// Combinational next-state of a 2-bit saturating direction counter.
// Ports:
//   ctr      - current counter value
//   taken    - resolved branch direction
//   ctr_nxt  - counter after training (saturates at CTR_SNT / CTR_ST)
// ---------------------------------------------------------------------------
module sat_ctr2
  import btb_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_nxt
);

  // Step one state toward the resolved direction, holding at either end.
  always_comb begin
    ctr_nxt = ctr;
    case (ctr)
      CTR_SNT: ctr_nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_nxt = taken ? CTR_ST  : CTR_WT;
      default: ctr_nxt = ctr;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB with 2-bit saturating direction counters. Fetch looks up
// combinationally; EX trains it once per resolved branch/jump.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   lookup_pc    - fetch PC (pre movc mux)
//   btb_hit      - valid entry, tag match and counter predicts taken
//   btb_nxt_pc   - predicted target, 0 when btb_hit is low
//   upd_valid    - a branch/jump resolved this cycle
//   upd_pc       - address of the resolved instruction
//   upd_taken    - resolved direction
//   upd_target   - resolved target (used when taken)
//   flush_all    - invalidate all entries on the next edge (beats an update)
// ---------------------------------------------------------------------------
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     lookup_pc,
  output logic            btb_hit,
  output logic [15:0]     btb_nxt_pc,
  input  logic            upd_valid,
  input  logic [15:0]     upd_pc,
  input  logic            upd_taken,
  input  logic [15:0]     upd_target,
  input  logic            flush_all
);

  localparam int NUM_ENTRIES = 1 << IDX_W;
  localparam int TAG_PAD     = TAG_FIELD_W - TAG_W;

  btb_entry_t table_q [NUM_ENTRIES];

  logic [IDX_W-1:0]       lkp_idx;
  logic [TAG_W-1:0]       lkp_tag;
  logic [TAG_FIELD_W-1:0] lkp_tag_ext;
  btb_entry_t             lkp_entry;

  logic [IDX_W-1:0]       upd_idx;
  logic [TAG_W-1:0]       upd_tag;
  logic [TAG_FIELD_W-1:0] upd_tag_ext;
  btb_entry_t             upd_entry;
  logic                   upd_tag_hit;
  ctr_t                   upd_ctr_nxt;

  assign lkp_idx     = lookup_pc[IDX_W-1:0];
  assign lkp_tag     = lookup_pc[15:IDX_W];
  assign lkp_tag_ext = {{TAG_PAD{1'b0}}, lkp_tag};
  assign lkp_entry   = table_q[lkp_idx];

  assign upd_idx     = upd_pc[IDX_W-1:0];
  assign upd_tag     = upd_pc[15:IDX_W];
  assign upd_tag_ext = {{TAG_PAD{1'b0}}, upd_tag};
  assign upd_entry   = table_q[upd_idx];
  assign upd_tag_hit = upd_entry.valid && (upd_entry.tag == upd_tag_ext);

  // Lookup reads only registered state, so an update in the same cycle is
  // invisible until after the edge (no write-through bypass).
  always_comb begin
    btb_hit    = lkp_entry.valid && (lkp_entry.tag == lkp_tag_ext) && lkp_entry.ctr[1];
    btb_nxt_pc = btb_hit ? lkp_entry.target : 16'h0000;
  end

  sat_ctr2 u_sat_ctr2 (
    .ctr     (upd_entry.ctr),
    .taken   (upd_taken),
    .ctr_nxt (upd_ctr_nxt)
  );

  // Table update: flush wins over training; a not-taken miss leaves the
  // resident entry alone so cold paths never evict a useful prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (flush_all) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_tag_hit) begin
        table_q[upd_idx].ctr <= upd_ctr_nxt;
        if (upd_taken) begin
          table_q[upd_idx].target <= upd_target;
        end
      end else if (upd_taken) begin
        table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag_ext, target: upd_target, ctr: CTR_ALLOC};
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
// Directed plus randomized checks of branch_target_buffer against a
// behavioural table model (16 entries, tag = pc >> 4).
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] lookup_pc;
  logic        btb_hit;
  logic [15:0] btb_nxt_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        flush_all;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the table contents.
  bit m_valid  [16];
  int m_tag    [16];
  int m_target [16];
  int m_ctr    [16];

  branch_target_buffer #(.IDX_W(4), .TAG_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_pc  (lookup_pc),
    .btb_hit    (btb_hit),
    .btb_nxt_pc (btb_nxt_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush_all  (flush_all)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset leaves every entry empty and weakly not-taken.
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = 0;
      m_ctr[i]    = 1;
    end
  endfunction

  // One clock edge of training as the behaviour is described: flush
  // dominates, hits train the counter, taken misses allocate.
  function automatic void model_edge(bit v, int pc, bit tk, int tgt, bit fl);
    int idx = pc % 16;
    int tg  = pc / 16;
    if (fl) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (v) begin
      if (m_valid[idx] && m_tag[idx] == tg) begin
        if (tk) begin
          m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_target[idx] = tgt;
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = tg;
        m_target[idx] = tgt;
        m_ctr[idx]    = 2;
      end
    end
  endfunction

  // Drive a lookup and compare both outputs against the model's prediction.
  task automatic checkOutput(input string name, input logic [15:0] pc);
    int  idx = int'(pc) % 16;
    bit  exp_hit;
    logic [15:0] exp_pc;
    lookup_pc = pc;
    #1;
    exp_hit = m_valid[idx] && (m_tag[idx] == int'(pc) / 16) && (m_ctr[idx] >= 2);
    exp_pc  = exp_hit ? 16'(m_target[idx]) : 16'h0000;
    checks++;
    assert (btb_hit === exp_hit) else begin
      errors++;
      $error("[TB] FAIL %s hit pc=%h: got %b expected %b", name, pc, btb_hit, exp_hit);
    end
    checks++;
    assert (btb_nxt_pc === exp_pc) else begin
      errors++;
      $error("[TB] FAIL %s nxt_pc pc=%h: got %h expected %h", name, pc, btb_nxt_pc, exp_pc);
    end
  endtask

  // Present one update (optionally with a pre-edge lookup), clock it, then
  // advance the model and return the update port to idle.
  task automatic applyStimulus(input bit v, input logic [15:0] pc, input bit tk,
                               input logic [15:0] tgt, input bit fl,
                               input bit peek, input logic [15:0] peek_pc,
                               input string name);
    @(negedge clk);
    upd_valid  = v;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    flush_all  = fl;
    if (peek) checkOutput(name, peek_pc);
    @(posedge clk);
    model_edge(v, int'(pc), tk, int'(tgt), fl);
    #1;
    upd_valid = 1'b0;
    flush_all = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    lookup_pc  = 16'h0000;
    upd_valid  = 1'b0;
    upd_pc     = 16'h0000;
    upd_taken  = 1'b0;
    upd_target = 16'h0000;
    flush_all  = 1'b0;
    model_reset();

    // Reset then lookup.
    #2;
    checkOutput("reset", 16'h0010);
    #10;
    rst_n = 1'b1;

    // Allocate and tag discrimination.
    applyStimulus(1, 16'h0023, 1, 16'h0040, 0, 0, 16'h0, "alloc");
    checkOutput("alloc_hit", 16'h0023);
    checkOutput("alloc_other_tag", 16'h0013);

    // Not-taken training down to strong NT, then taken back to strong T.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 16'h0023, 0, 16'h0000, 0, 0, 16'h0, "nt");
      checkOutput("train_nt", 16'h0023);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'h0023, 1, 16'h0040 + 16'(i), 0, 0, 16'h0, "tk");
      checkOutput("train_tk", 16'h0023);
    end

    // Not-taken miss never allocates; taken conflict evicts.
    applyStimulus(1, 16'h0005, 0, 16'h0300, 0, 0, 16'h0, "nt_miss");
    checkOutput("nt_miss", 16'h0005);
    applyStimulus(1, 16'h0005, 1, 16'h0100, 0, 0, 16'h0, "alloc5");
    checkOutput("alloc5", 16'h0005);
    applyStimulus(1, 16'h1005, 1, 16'h2000, 0, 0, 16'h0, "evict");
    checkOutput("evicted", 16'h0005);
    checkOutput("evictor", 16'h1005);

    // Clear the table, then allocate while looking up the same PC.
    applyStimulus(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0, "flush");
    checkOutput("flushed", 16'h0023);
    applyStimulus(1, 16'h0023, 1, 16'h0077, 0, 1, 16'h0023, "same_cycle_pre");
    checkOutput("same_cycle_post", 16'h0023);

    // Flush together with a taken update drops the update.
    applyStimulus(1, 16'h0033, 1, 16'h0099, 1, 0, 16'h0, "flush_upd");
    checkOutput("flush_upd_old", 16'h0023);
    checkOutput("flush_upd_new", 16'h0033);

    // Randomized training over a small conflicting PC pool.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] pc, lpc, tgt;
      bit v, tk, fl;
      pc  = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 7));
      lpc = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 7));
      tgt = 16'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 39) == 0);
      applyStimulus(v, pc, tk, tgt, fl, 1, lpc, "random");
    end

    // Populate an entry and assert reset between edges.
    applyStimulus(1, 16'h0042, 1, 16'h1234, 0, 0, 16'h0, "pre_rst");
    checkOutput("pre_rst", 16'h0042);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    checkOutput("async_rst", 16'h0042);
    #1;
    rst_n = 1'b1;
    checkOutput("after_rst", 16'h0042);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters. It serves the fetch stage: each cycle it takes the pre-mux fetch PC and combinationally returns a predicted-taken hit plus the predicted target. The EX stage writes to it, once per resolved branch or jump, with the outcome, so the buffer trains on committed control flow. It is the responder side of the PC unit's `btb_hit` / `btb_nxt_pc` interface.

## Interface
- `IDX_W`, default 4: index bits; table holds 2^IDX_W entries.
- `TAG_W`, default 12: tag bits; must equal 16 − IDX_W.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `lookup_pc`  in  16  fetch PC before the movc mux (unregistered PC-unit output)
- `btb_hit`  out  1  entry valid, tag match and counter predicts taken
- `btb_nxt_pc`  out  16  predicted target; 16'h0000 when `btb_hit`=0
- `upd_valid`  in  1  EX stage resolved a branch or jump this cycle
- `upd_pc`  in  16  address of the resolved branch instruction itself (not PC+1)
- `upd_taken`  in  1  resolved direction
- `upd_target`  in  16  resolved target address, meaningful when `upd_taken`=1
- `flush_all`  in  1  synchronous invalidate of every entry

## Operation
- Entry fields: `valid`, `tag[TAG_W-1:0]`, `target[15:0]`, `ctr[1:0]`. Index = pc[IDX_W-1:0]. Tag = pc[15:IDX_W].
- Lookup is purely combinational on the registered table:
  - `btb_hit` = valid & (tag == lookup_pc[15:IDX_W]) & ctr[1].
  - When `btb_hit`=1, `btb_nxt_pc` = target.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Increment and decrement saturate at 11 and 00; there is no wrap.
- Update on a clock edge with `upd_valid`=1 and `flush_all`=0, entry at upd index:
  - **Tag hit** (valid and tags equal):
    - `upd_taken`=1: ctr increments and target is overwritten with `upd_target`.
    - `upd_taken`=0: ctr decrements and target is unchanged.
  - **Miss** (invalid or tag differs):
    - `upd_taken`=1: allocate. valid=1, tag written, target written, ctr=10.
    - `upd_taken`=0: no change. A not-taken miss never evicts.
- `flush_all`=1 clears every valid bit on the next edge. It has priority over a same-cycle update, which is dropped.
- Stalls are not an input. The caller guarantees `upd_valid` pulses exactly once per resolved instruction.

## Timing
- Lookup latency is 0 cycles, combinational from `lookup_pc` to `btb_hit` / `btb_nxt_pc`. The table is flops, not SRAM.
- Update latency is 1 cycle. State written at edge N is visible to lookups after edge N.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. There is no write-through bypass.
- Reset (async assert): all valid=0, ctr=01, tag=0, target=0. Hence `btb_hit`=0 and `btb_nxt_pc`=0 immediately. Reset mid-update discards the update.
- No output depends combinationally on any `upd_*` or `flush_all` input.

## Structure
- Package `btb_pkg`:
  - `btb_entry_t` struct {valid, tag, target, ctr}.
  - Counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - `CTR_ALLOC = CTR_WT`.
- Sub-module `sat_ctr2`: combinational next-count from (ctr, taken). It is instantiated once, on the update path.
- Table is an array of `btb_entry_t` registers written through a single update port.

## Test plan
- **Reset then lookup.** Reset, lookup_pc=16'h0010 → btb_hit=0, btb_nxt_pc=16'h0000.
- **Allocate.** Update pc=16'h0023 taken, target=16'h0040. Next cycle lookup 16'h0023 → hit=1, nxt_pc=16'h0040. Lookup 16'h0013 (same index, different tag) → hit=0.
- **Saturation and training.**
  - Allocated entry, three not-taken updates → ctr 10→01→00→00; lookup hit=0 after the first.
  - Four taken updates → ctr reaches 11; hit=1 from the second.
- **Not-taken miss and conflict.**
  - Not-taken update to empty pc=16'h0005 → entry stays invalid.
  - Taken update pc=16'h1005, target 16'h2000, evicts an existing pc=16'h0005 entry; lookup 16'h0005 → hit=0.
- **Simultaneous events.**
  - Lookup 16'h0023 in the same cycle as a first-allocate update for 16'h0023 → hit=0 that cycle, hit=1 next cycle.
  - flush_all together with a taken update → all entries invalid and the update is dropped.
- **Async reset mid-run.** Populated table, assert rst_n low between edges → btb_hit drops to 0 without waiting for a clock.
